// File: rtl/lsu_mc_if.sv
// Interfaces for the load/store unit: core request/response channel and
// data-memory valid/ready channel.
interface lsu_mc_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic              resp_misalign;
    logic              resp_illegal;

    // Core side drives requests and accepts responses.
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_misalign, resp_illegal
    );

    // LSU side.
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_misalign, resp_illegal
    );
endinterface

interface lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] Address;
    logic              MemWrite;
    logic              MemRead;
    logic [XLEN-1:0]   Write_data;
    logic [XLEN/8-1:0] Write_strb;
    logic              Mem_Req_Ready;
    logic [XLEN-1:0]   Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ready;

    // LSU side issues memory requests.
    modport master (
        output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    // Memory side.
    modport slave (
        input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ready,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/lsu_mc.sv
// Multicycle load/store unit: one request per transaction, lane extraction,
// sign/zero extension, fault detection and performance counters.
module lsu_mc #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    lsu_mc_if.slave     core,
    lsu_mem_if.master   mem,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] stall_cnt
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_REQ  = 3'd1;
    localparam logic [2:0] S_LD_WAIT = 3'd2;
    localparam logic [2:0] S_ST_REQ  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   resp_data_q;
    logic              misalign_q;
    logic              illegal_q;
    logic [31:0]       load_cnt_q, store_cnt_q, stall_cnt_q;

    logic [OFF_W-1:0]  off;
    logic [XLEN-1:0]   rd_shift;
    logic              req_ill, req_mis, accept, stall;

    // Unsupported encodings; doubles only exist on RV64.
    function automatic logic is_illegal(input logic st, input logic [2:0] f3);
        logic ill;
        ill = (f3 == 3'b111) || (st && f3[2]);
        if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))
            ill = 1'b1;
        return ill;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
        logic m;
        case (sz)
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            2'b10:   m = |a[1:0];
            default: m = |a[2:0];
        endcase
        return m;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Extends the already right-aligned lane according to size and funct3[2].
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] w, input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] wd;
        logic [XLEN-1:0]    r;
        b  = w[7:0];
        h  = w[15:0];
        wd = w[31:0];
        case (f3)
            3'b000:  r = XLEN'(b);
            3'b001:  r = XLEN'(h);
            3'b010:  r = XLEN'(wd);
            3'b100:  r = XLEN'(w[7:0]);
            3'b101:  r = XLEN'(w[15:0]);
            3'b110:  r = XLEN'(w[31:0]);
            default: r = w;
        endcase
        return r;
    endfunction

    assign off      = addr_q[OFF_W-1:0];
    assign rd_shift = mem.Read_data >> {off, 3'b000};
    assign req_ill  = is_illegal(core.req_store, core.req_funct3);
    assign req_mis  = !req_ill && is_misaligned(core.req_funct3[1:0], core.req_addr[2:0]);
    assign accept   = (state_q == S_IDLE) && core.req_valid;
    assign stall    = ((state_q == S_LD_REQ || state_q == S_ST_REQ) && !mem.Mem_Req_Ready) ||
                      ((state_q == S_LD_WAIT) && !mem.Read_data_Valid);

    assign core.req_ready     = (state_q == S_IDLE);
    assign core.resp_valid    = (state_q == S_RESP);
    assign core.resp_data     = resp_data_q;
    assign core.resp_misalign = misalign_q;
    assign core.resp_illegal  = illegal_q;

    assign mem.MemRead         = (state_q == S_LD_REQ);
    assign mem.MemWrite        = (state_q == S_ST_REQ);
    assign mem.Read_data_Ready = (state_q == S_LD_WAIT);
    assign mem.Address         = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem.Write_data      = wdata_q << {off, 3'b000};
    assign mem.Write_strb      = STRB_W'(size_mask(funct3_q[1:0])) << off;

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // Next-state decode of the transaction FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (core.req_valid) begin
                    if (req_ill || req_mis) state_d = S_RESP;
                    else if (core.req_store) state_d = S_ST_REQ;
                    else                     state_d = S_LD_REQ;
                end
            end
            S_LD_REQ:  if (mem.Mem_Req_Ready)   state_d = S_LD_WAIT;
            S_LD_WAIT: if (mem.Read_data_Valid) state_d = S_RESP;
            S_ST_REQ:  if (mem.Mem_Req_Ready)   state_d = S_RESP;
            S_RESP:    if (core.resp_ready)     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State, latched request, response registers and counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                store_q     <= core.req_store;
                funct3_q    <= core.req_funct3;
                addr_q      <= core.req_addr;
                wdata_q     <= core.req_wdata;
                resp_data_q <= '0;
                misalign_q  <= req_mis;
                illegal_q   <= req_ill;
            end
            if (state_q == S_LD_WAIT && mem.Read_data_Valid)
                resp_data_q <= extend_load(rd_shift, funct3_q);
            if (state_q == S_RESP && core.resp_ready && !misalign_q && !illegal_q) begin
                if (store_q) store_cnt_q <= store_cnt_q + 32'd1;
                else         load_cnt_q  <= load_cnt_q + 32'd1;
            end
            if (stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc: a vector table on an RV32 instance plus
// hand-written RV64, response-hold and mid-transaction reset sequences.
module tb_lsu_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    lsu_mc_if  #(.XLEN(32), .ADDR_W(32)) c32();
    lsu_mem_if #(.XLEN(32), .ADDR_W(32)) m32();
    lsu_mc_if  #(.XLEN(64), .ADDR_W(32)) c64();
    lsu_mem_if #(.XLEN(64), .ADDR_W(32)) m64();
    logic [31:0] lc32, sc32, stc32, lc64, sc64, stc64;

    lsu_mc #(.XLEN(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst(rst), .core(c32), .mem(m32),
        .load_cnt(lc32), .store_cnt(sc32), .stall_cnt(stc32)
    );
    lsu_mc #(.XLEN(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst(rst), .core(c64), .mem(m64),
        .load_cnt(lc64), .store_cnt(sc64), .stall_cnt(stc64)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          stalls;
        logic [31:0] e_data;
        logic        e_mis;
        logic        e_ill;
        int          e_lat;
        int          e_memcyc;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 16;
    vec_t v[NV];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn32(input vec_t t, output logic [31:0] d, output logic mis, output logic ill,
                         output int lat, output int memcyc, output logic [31:0] a,
                         output logic [3:0] s, output logic [31:0] w);
        int reqc;
        int guard;
        reqc = 0; memcyc = 0; a = '0; s = '0; w = '0;
        c32.req_valid = 1'b1; c32.req_store = t.st; c32.req_funct3 = t.f3;
        c32.req_addr = t.addr; c32.req_wdata = t.wd;
        m32.Read_data = t.rd; m32.Read_data_Valid = 1'b1; m32.Mem_Req_Ready = 1'b0;
        step();
        c32.req_valid = 1'b0;
        lat = 1;
        guard = 0;
        while (!c32.resp_valid && guard < 50) begin
            if (m32.MemRead || m32.MemWrite) begin
                memcyc++;
                a = m32.Address; s = m32.Write_strb; w = m32.Write_data;
                m32.Mem_Req_Ready = (reqc >= t.stalls);
                reqc++;
            end else begin
                m32.Mem_Req_Ready = 1'b0;
            end
            step();
            lat++;
            guard++;
        end
        if (guard >= 50) chk("resp_timeout", 64'd0, 64'd1);
        d = c32.resp_data; mis = c32.resp_misalign; ill = c32.resp_illegal;
        c32.resp_ready = 1'b1;
        step();
        c32.resp_ready = 1'b0;
        m32.Mem_Req_Ready = 1'b0;
    endtask

    task automatic txn64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] rd,
                         output logic [63:0] d, output logic [31:0] a, output int lat);
        int guard;
        a = '0;
        c64.req_valid = 1'b1; c64.req_store = 1'b0; c64.req_funct3 = f3;
        c64.req_addr = addr; c64.req_wdata = '0;
        m64.Read_data = rd; m64.Read_data_Valid = 1'b1; m64.Mem_Req_Ready = 1'b1;
        step();
        c64.req_valid = 1'b0;
        lat = 1;
        guard = 0;
        while (!c64.resp_valid && guard < 50) begin
            if (m64.MemRead) a = m64.Address;
            step();
            lat++;
            guard++;
        end
        if (guard >= 50) chk("resp64_timeout", 64'd0, 64'd1);
        d = c64.resp_data;
        c64.resp_ready = 1'b1;
        step();
        c64.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, a, w;
        logic [63:0] d64;
        logic [3:0]  s;
        logic        mis, ill;
        int          lat, memcyc, guard;

        //        st    f3      addr          wd            rd            stl data          mis   ill   lat mc addr          strb     wd
        v[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 3, 1, 32'h0000_0100, 4'b0000, 32'h0};
        v[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 32'h0000_0080, 1'b0, 1'b0, 3, 1, 32'h0000_0100, 4'b0000, 32'h0};
        v[2]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 32'hFFFF_80FF, 1'b0, 1'b0, 3, 1, 32'h0000_0100, 4'b0000, 32'h0};
        v[3]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF_1234, 0, 32'h0000_1234, 1'b0, 1'b0, 3, 1, 32'h0000_0100, 4'b0000, 32'h0};
        v[4]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3, 1, 32'h0000_0200, 4'b0000, 32'h0};
        v[5]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        2, 32'h0,         1'b0, 1'b0, 4, 3, 32'h0000_0200, 4'b1100, 32'hBEEF_0000};
        v[6]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, 32'h0,         1'b0, 1'b0, 2, 1, 32'h0000_0300, 4'b0010, 32'h0000_A500};
        v[7]  = '{1'b1, 3'b010, 32'h0000_0304, 32'h1234_5678, 32'h0,        0, 32'h0,         1'b0, 1'b0, 2, 1, 32'h0000_0304, 4'b1111, 32'h1234_5678};
        v[8]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,         1'b1, 1'b0, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[9]  = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,         1'b1, 1'b0, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[10] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,         1'b0, 1'b1, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[11] = '{1'b0, 3'b011, 32'h0000_0101, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,         1'b0, 1'b1, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[12] = '{1'b1, 3'b100, 32'h0000_0100, 32'h0000_0011, 32'h0,        0, 32'h0,         1'b0, 1'b1, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[13] = '{1'b0, 3'b111, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,         1'b0, 1'b1, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[14] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 0, 32'h0,         1'b0, 1'b1, 1, 0, 32'h0,         4'b0000, 32'h0};
        v[15] = '{1'b1, 3'b001, 32'h0000_0201, 32'h0000_1111, 32'h0,        0, 32'h0,         1'b1, 1'b0, 1, 0, 32'h0,         4'b0000, 32'h0};

        rst = 1'b0;
        c32.req_valid = 1'b0; c32.req_store = 1'b0; c32.req_funct3 = 3'b000;
        c32.req_addr = '0; c32.req_wdata = '0; c32.resp_ready = 1'b0;
        m32.Mem_Req_Ready = 1'b0; m32.Read_data = '0; m32.Read_data_Valid = 1'b0;
        c64.req_valid = 1'b0; c64.req_store = 1'b0; c64.req_funct3 = 3'b000;
        c64.req_addr = '0; c64.req_wdata = '0; c64.resp_ready = 1'b0;
        m64.Mem_Req_Ready = 1'b0; m64.Read_data = '0; m64.Read_data_Valid = 1'b0;
        step();
        step();
        rst = 1'b1;

        chk("rst_req_ready", 64'(c32.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(c32.resp_valid), 64'd0);
        chk("rst_memread", 64'(m32.MemRead), 64'd0);
        chk("rst_memwrite", 64'(m32.MemWrite), 64'd0);
        chk("rst_rd_ready", 64'(m32.Read_data_Ready), 64'd0);
        chk("rst_counters", 64'({lc32, sc32 | stc32}), 64'd0);

        for (int i = 0; i < NV; i++) begin
            txn32(v[i], d, mis, ill, lat, memcyc, a, s, w);
            chk($sformatf("v%0d_data", i), 64'(d), 64'(v[i].e_data));
            chk($sformatf("v%0d_misalign", i), 64'(mis), 64'(v[i].e_mis));
            chk($sformatf("v%0d_illegal", i), 64'(ill), 64'(v[i].e_ill));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].e_lat));
            chk($sformatf("v%0d_mem_cycles", i), 64'(memcyc), 64'(v[i].e_memcyc));
            if (v[i].e_memcyc > 0)
                chk($sformatf("v%0d_address", i), 64'(a), 64'(v[i].e_addr));
            if (v[i].st && v[i].e_memcyc > 0) begin
                chk($sformatf("v%0d_strb", i), 64'(s), 64'(v[i].e_strb));
                chk($sformatf("v%0d_wdata", i), 64'(w), 64'(v[i].e_wd));
            end
        end
        chk("load_cnt_table", 64'(lc32), 64'd5);
        chk("store_cnt_table", 64'(sc32), 64'd3);
        chk("stall_cnt_table", 64'(stc32), 64'd2);

        // RV64: lane extraction from the upper word and doubleword loads.
        txn64(3'b110, 32'h0000_1004, 64'h8765_4321_0000_0000, d64, a, lat);
        chk("x64_lwu_data", d64, 64'h0000_0000_8765_4321);
        chk("x64_lwu_addr", 64'(a), 64'h1000);
        chk("x64_lwu_lat", 64'(lat), 64'd3);
        txn64(3'b010, 32'h0000_1004, 64'h8765_4321_0000_0000, d64, a, lat);
        chk("x64_lw_data", d64, 64'hFFFF_FFFF_8765_4321);
        txn64(3'b011, 32'h0000_1008, 64'h1122_3344_5566_7788, d64, a, lat);
        chk("x64_ld_data", d64, 64'h1122_3344_5566_7788);
        chk("x64_ld_addr", 64'(a), 64'h1008);
        chk("x64_load_cnt", 64'(lc64), 64'd3);

        // Response hold with resp_ready low and a competing request pending.
        c32.req_valid = 1'b1; c32.req_store = 1'b0; c32.req_funct3 = 3'b010;
        c32.req_addr = 32'h0000_0500; c32.req_wdata = '0;
        m32.Read_data = 32'hCAFE_F00D; m32.Read_data_Valid = 1'b1; m32.Mem_Req_Ready = 1'b1;
        step();
        c32.req_funct3 = 3'b000; c32.req_addr = 32'h0000_0600;
        guard = 0;
        while (!c32.resp_valid && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) chk("hold_timeout", 64'd0, 64'd1);
        m32.Read_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d_valid", k), 64'(c32.resp_valid), 64'd1);
            chk($sformatf("hold%0d_data", k), 64'(c32.resp_data), 64'hCAFE_F00D);
            chk($sformatf("hold%0d_req_ready", k), 64'(c32.req_ready), 64'd0);
            step();
        end
        c32.req_valid = 1'b0;
        c32.resp_ready = 1'b1;
        step();
        c32.resp_ready = 1'b0;
        chk("hold_after_req_ready", 64'(c32.req_ready), 64'd1);
        chk("hold_after_resp_valid", 64'(c32.resp_valid), 64'd0);
        chk("hold_load_cnt", 64'(lc32), 64'd6);

        // Reset while waiting for read data abandons the load.
        c32.req_valid = 1'b1; c32.req_store = 1'b0; c32.req_funct3 = 3'b010;
        c32.req_addr = 32'h0000_0400;
        m32.Read_data_Valid = 1'b0; m32.Mem_Req_Ready = 1'b1;
        step();
        c32.req_valid = 1'b0;
        step();
        chk("rstmid_in_wait", 64'(m32.Read_data_Ready), 64'd1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rstmid_req_ready", 64'(c32.req_ready), 64'd1);
        chk("rstmid_resp_valid", 64'(c32.resp_valid), 64'd0);
        chk("rstmid_load_cnt", 64'(lc32), 64'd0);
        chk("rstmid_store_cnt", 64'(sc32), 64'd0);
        chk("rstmid_stall_cnt", 64'(stc32), 64'd0);
        m32.Read_data_Valid = 1'b1;
        step();
        chk("rstmid_no_resp", 64'(c32.resp_valid), 64'd0);
        chk("rstmid_no_read", 64'(m32.MemRead), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
- Parametrised load/store unit for the multicycle RISC-V core.
- Takes one decoded memory request per transaction from the core FSM.
- Drives the valid/ready data-memory channel and returns lane-extracted, sign/zero-extended load data.
- Generalises the inline 32-bit load/store datapath: XLEN 32 or 64, misalignment/illegal detection, held response handshake, and load/store/stall performance counters.

Parameters:
- XLEN, 32: data width; 32 or 64 only.
- ADDR_W, 32: address width.
- STRB_W, XLEN/8: byte-strobe width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  core presents request.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 of load/store.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  core accepts response.
- resp_data  out  XLEN  extended load data; 0 for stores and faults.
- resp_misalign  out  1  address not size-aligned; no memory access made.
- resp_illegal  out  1  unsupported funct3; no memory access made.
- Address  out  ADDR_W  req_addr with low log2(STRB_W) bits zeroed.
- MemWrite  out  1  store request valid.
- MemRead  out  1  load request valid.
- Write_data  out  XLEN  req_wdata shifted left by 8*byte offset.
- Write_strb  out  STRB_W  byte enables, size mask shifted by byte offset.
- Mem_Req_Ready  in  1  memory accepts request.
- Read_data  in  XLEN  memory read word.
- Read_data_Valid  in  1  read data valid.
- Read_data_Ready  out  1  LSU accepts read data.
- load_cnt  out  32  completed loads.
- store_cnt  out  32  completed stores.
- stall_cnt  out  32  memory wait cycles.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; counters 0; latched request and resp_data/flags 0.
  - Outputs after reset: req_ready=1; resp_valid, MemRead, MemWrite, Read_data_Ready all 0.
  - A reset mid-transaction abandons it; no response is produced.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ, RESP.
  - All handshake outputs decode from the current state only.
  - Address, Write_data and Write_strb come from registered request fields.
- IDLE:
  - Request accepted on req_valid & req_ready; all request fields are latched.
  - Fault check first. If faulted, go to RESP with the flag set and resp_data=0.
  - Otherwise a load goes to LD_REQ and a store goes to ST_REQ.
- Size encoding (funct3[1:0]): 00=byte, 01=half, 10=word, 11=double.
  - funct3[2]=1 means zero-extend.
- Illegal cases:
  - funct3=111.
  - Store with funct3[2]=1.
  - With XLEN=32: funct3 011 or 110.
- Misaligned: addr mod size != 0. Illegal takes priority over misaligned.
- LD_REQ: MemRead=1 until Mem_Req_Ready, then LD_WAIT.
- LD_WAIT: Read_data_Ready=1. On Read_data_Valid:
  - resp_data = extend(Read_data >> 8*offset, size).
  - Go to RESP.
- ST_REQ: MemWrite=1 until Mem_Req_Ready, then RESP.
- RESP:
  - resp_valid=1; resp_data and flags held stable until resp_ready, then IDLE.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Minimum latency, acceptance edge to resp_valid:
  - Load: 3 cycles (zero-wait memory).
  - Store: 2 cycles.
  - Fault: 1 cycle.
- Counters:
  - load_cnt increments when a non-faulted load response is accepted.
  - store_cnt increments when a non-faulted store response is accepted.
  - stall_cnt increments every cycle in LD_REQ or ST_REQ with Mem_Req_Ready=0, and every cycle in LD_WAIT with Read_data_Valid=0.
  - All counters wrap modulo 2^32.
- Read_data_Valid outside LD_WAIT is ignored. Mem_Req_Ready outside LD_REQ/ST_REQ is ignored.

Test Plan:
- XLEN=32, lb at addr 0x103, Read_data=0x80FF_1234, zero-wait memory:
  - Address=0x100; resp_data=0xFFFF_FF80.
  - resp_valid 3 cycles after acceptance; load_cnt=1.
- XLEN=32, sh at addr 0x202, wdata=0x0000_BEEF, Mem_Req_Ready low 2 cycles:
  - MemWrite held 3 cycles; Write_strb=1100; Write_data=0xBEEF_0000.
  - stall_cnt=2; store_cnt=1.
- XLEN=32, lw at addr 0x101:
  - No MemRead; resp_misalign=1 and resp_data=0 one cycle later; load_cnt unchanged.
- XLEN=32, load with funct3=011:
  - resp_illegal=1 and resp_misalign=0; no memory access.
- XLEN=64, lwu at addr 0x1004, Read_data=0x8765_4321_0000_0000:
  - Address=0x1000; resp_data=0x0000_0000_8765_4321.
- Load in LD_WAIT, rst=0 for one cycle:
  - Next cycle IDLE, req_ready=1, all counters 0, no resp_valid.
- Response hold: resp_ready held low 4 cycles:
  - resp_valid and resp_data remain stable; req_ready stays 0 until the accept.
